// File: rtl/simd_satadd_pipe_pkg.sv
// simd_satadd_pipe_pkg: mode-bit layout and saturation constants shared by the SIMD add/sub pipeline.
package simd_satadd_pipe_pkg;
    localparam int MODE_SUB = 0;
    localparam int MODE_UNS = 1;
    localparam int MODE_SAT = 2;
    localparam int MODE_W   = 3;
    function automatic logic [63:0] sat_smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction
    function automatic logic [63:0] sat_smin(input int w);
        return 64'd1 << (w - 1);
    endfunction
    function automatic logic [63:0] sat_umax(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/simd_lane_addsub.sv
// simd_lane_addsub: one lane's raw add/sub (stage-1 half) and overflow/saturation select (stage-2 half).
module simd_lane_addsub
    import simd_satadd_pipe_pkg::*;
#(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic              i_sub,
    output logic [LANE_W:0]   o_raw,
    input  logic [LANE_W:0]   i_raw,
    input  logic              i_a_msb,
    input  logic              i_b_msb,
    input  logic [MODE_W-1:0] i_mode,
    output logic [LANE_W-1:0] o_sum,
    output logic              o_ovf
);
    localparam logic [LANE_W-1:0] SMAX = LANE_W'(sat_smax(LANE_W));
    localparam logic [LANE_W-1:0] SMIN = LANE_W'(sat_smin(LANE_W));
    localparam logic [LANE_W-1:0] UMAX = LANE_W'(sat_umax(LANE_W));
    logic w_sovf;
    logic w_uovf;
    logic [LANE_W-1:0] w_sat_val;
    assign o_raw = {1'b0, i_a} + {1'b0, i_sub ? ~i_b : i_b} + (LANE_W+1)'(i_sub);
    // B enters inverted on subtract, so the operand-sign test flips.
    assign w_sovf = (i_mode[MODE_SUB] ? i_a_msb != i_b_msb : i_a_msb == i_b_msb)
                    && i_raw[LANE_W-1] != i_a_msb;
    assign w_uovf = i_raw[LANE_W] ^ i_mode[MODE_SUB];
    assign o_ovf = i_mode[MODE_UNS] ? w_uovf : w_sovf;
    assign w_sat_val = i_mode[MODE_UNS] ? (i_mode[MODE_SUB] ? '0 : UMAX)
                                        : (i_a_msb ? SMIN : SMAX);
    assign o_sum = (o_ovf && i_mode[MODE_SAT]) ? w_sat_val : i_raw[LANE_W-1:0];
endmodule

// File: rtl/simd_satadd_pipe.sv
// simd_satadd_pipe: two-stage valid/ready SIMD add/sub with per-lane saturation and sticky flags.
module simd_satadd_pipe
    import simd_satadd_pipe_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    localparam int DW    = LANES * LANE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    A,
    input  logic [DW-1:0]    B,
    input  logic             sub,
    input  logic             uns,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    Sum,
    output logic [LANES-1:0] sat_lane,
    output logic [LANES-1:0] sticky_sat,
    input  logic             clr_sticky
);
    localparam int RW = LANE_W + 1;
    logic w_s1_load;
    logic w_s2_load;
    logic r_s1_valid;
    logic r_s2_valid;
    logic [LANES*RW-1:0] w_raw;
    logic [LANES*RW-1:0] r_s1_raw;
    logic [LANES-1:0] r_s1_a_msb;
    logic [LANES-1:0] r_s1_b_msb;
    logic [LANES-1:0] w_ovf;
    logic [LANES-1:0] r_sat;
    logic [LANES-1:0] r_sticky;
    logic [MODE_W-1:0] w_mode;
    logic [MODE_W-1:0] r_s1_mode;
    logic [DW-1:0] w_sum;
    logic [DW-1:0] r_sum;
    assign w_mode[MODE_SUB] = sub;
    assign w_mode[MODE_UNS] = uns;
    assign w_mode[MODE_SAT] = sat_en;
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane_addsub #(.LANE_W(LANE_W)) u_lane (
            .i_a     (A[i*LANE_W +: LANE_W]),
            .i_b     (B[i*LANE_W +: LANE_W]),
            .i_sub   (sub),
            .o_raw   (w_raw[i*RW +: RW]),
            .i_raw   (r_s1_raw[i*RW +: RW]),
            .i_a_msb (r_s1_a_msb[i]),
            .i_b_msb (r_s1_b_msb[i]),
            .i_mode  (r_s1_mode),
            .o_sum   (w_sum[i*LANE_W +: LANE_W]),
            .o_ovf   (w_ovf[i])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_a_msb <= '0;
            r_s1_b_msb <= '0;
            r_s1_mode  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            r_s1_raw   <= w_raw;
            r_s1_mode  <= w_mode;
            for (int l = 0; l < LANES; l++) begin
                r_s1_a_msb[l] <= A[l*LANE_W + LANE_W - 1];
                r_s1_b_msb[l] <= B[l*LANE_W + LANE_W - 1];
            end
        end
    end
    // Sticky clear takes effect before the same-cycle handshake ORs in new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_sat      <= '0;
            r_sticky   <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_sum <= w_sum;
                    r_sat <= w_ovf;
                end
            end
            r_sticky <= (clr_sticky ? '0 : r_sticky) | ((r_s2_valid && out_ready) ? r_sat : '0);
        end
    end
    assign out_valid  = r_s2_valid;
    assign Sum        = r_sum;
    assign sat_lane   = r_sat;
    assign sticky_sat = r_sticky;
endmodule

// File: doc/simd_satadd_pipe.md
Name: simd_satadd_pipe

Overview:
Parametrised, pipelined SIMD add/subtract unit. Successor to the 4x4-bit PADDSB datapath in Execute.
- Handles LANES independent lanes of LANE_W bits each.
- Per-transaction mode: add or sub, signed or unsigned, saturate or wrap.
- Two-stage valid/ready pipeline with backpressure.
- Reports saturation per lane, per result, plus sticky per-lane flags for status/debug.

Parameters:
- LANE_W, 4, bits per lane (>=2).
- LANES, 4, number of lanes (>=1); data width DW = LANES*LANE_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept an input this cycle.
- A  in  DW  operand vector; lane i = A[i*LANE_W +: LANE_W].
- B  in  DW  operand vector, same lane layout.
- sub  in  1  0 = A+B, 1 = A-B (per transaction).
- uns  in  1  0 = two's-complement lanes, 1 = unsigned lanes.
- sat_en  in  1  1 = saturate on overflow, 0 = wrap.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- Sum  out  DW  result vector, same lane layout.
- sat_lane  out  LANES  per-lane overflow/underflow flag for the current result.
- sticky_sat  out  LANES  accumulated sat_lane flags since last clear.
- clr_sticky  in  1  synchronous clear of sticky_sat.

Behaviour:
- Reset (rst_n low, async): both stage valids = 0, out_valid = 0, Sum = 0, sat_lane = 0, sticky_sat = 0. in_ready = 1 once reset deasserts.
- Reset mid-operation: in-flight transactions are dropped, no partial outputs.
- Input handshake: in_valid && in_ready.
- Output handshake: out_valid && out_ready.
- Latency: exactly 2 cycles from input handshake to out_valid when there is no stall. Throughput is 1 per cycle.
- Stage 1: registers the per-lane raw LANE_W+1-bit result (A + (sub ? ~B : B) + sub), plus operand MSBs and mode bits.
- Stage 2: applies saturation, registers Sum and sat_lane.
- Pipeline advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads. A combinational ready path is permitted.
- Stall: while out_valid && !out_ready, Sum and sat_lane hold stable. Results are never dropped or reordered.
- Overflow detection per lane:
  - signed add: overflow when operand MSBs are equal and result MSB differs.
  - signed sub: overflow when operand MSBs differ and result MSB differs from A's MSB.
  - unsigned add: overflow on carry-out.
  - unsigned sub: overflow on borrow (carry-out = 0).
- Saturation values (sat_en = 1):
  - signed positive overflow -> 2^(LANE_W-1)-1.
  - signed negative overflow -> -2^(LANE_W-1).
  - unsigned add -> all ones.
  - unsigned sub -> 0.
  - Positive vs negative is taken from A's MSB: A negative -> negative saturation.
- sat_en = 0: Sum = wrapped low LANE_W bits. sat_lane still reports overflow.
- No carry propagates between lanes.
- sticky_sat:
  - On each output handshake, sticky_sat |= sat_lane.
  - clr_sticky clears it.
  - If clr_sticky and an output handshake occur in the same cycle, the result is sticky_sat = sat_lane of that result: clear first, then set.
- With LANE_W=4, LANES=4, sub=0, uns=0, sat_en=1, Sum matches the legacy PADDSB result.

Decomposition:
- Shared header (simd_defs.vh): mode bit positions and the saturation constant functions (signed max/min, unsigned max) as localparams/functions, parametrised by LANE_W.
- Sub-module simd_lane_addsub: combinational single-lane raw add/sub plus overflow/saturation-select logic, parametrised by LANE_W.
  - Stage-1 half: raw sum and carry.
  - Stage-2 half: saturation mux.
  - Instantiated LANES times via generate.
- Top level holds the pipeline registers, handshake logic and sticky register.

Test Plan:
1. Defaults; signed add with saturation.
   - Stimulus: A=16'h783F, B=16'h1F21.
   - Required: Sum=16'h7850, sat_lane=4'b1100, out_valid exactly 2 cycles after accept.
2. Signed sub with saturation.
   - Stimulus: A=16'h8705, B=16'h1F15.
   - Required: Sum=16'h87F0, sat_lane=4'b1100.
3. Unsigned add and unsigned sub with saturation.
   - Add: A=16'hF801, B=16'h1801 -> Sum=16'hFF02, sat_lane=4'b1100.
   - Sub: A=16'h053F, B=16'h1630 -> Sum=16'h000F, sat_lane=4'b1100.
4. Wrap mode (sat_en=0).
   - Stimulus: A=16'h783F, B=16'h1F21.
   - Required: Sum=16'h8750, sat_lane=4'b1100.
5. Backpressure.
   - Stimulus: issue 3 back-to-back transactions with out_ready=0.
   - Required: in_ready falls after the 2nd accept; Sum holds first result stable. After out_ready=1, results emerge in order, one per cycle.
   - Also: random streaming over 10k transactions matches a reference model.
6. Sticky flags and reset.
   - Sticky: run test 1, then a non-saturating result -> sticky_sat=4'b1100. Assert clr_sticky during a handshake whose sat_lane=4'b0001 -> sticky_sat=4'b0001.
   - Reset: assert rst_n low with both stages full -> out_valid, Sum, sticky_sat go to 0 immediately (async).
   - Parameter sweep: repeat tests 1-5 with LANE_W=8, LANES=2 and LANE_W=2, LANES=8.
